spi_req_arbiter: RTL
====================

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesters/slaves; DATA_WIDTH, default 6, SPI word length; GAP_CYCLES, default 4, idle clk cycles between transactions (>=1); TIMEOUT_CYCLES, default 1024, maximum clk cycles from m_start to m_finish.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  NUM_REQ  per-requester transaction request, level, held until done or err.
REQ-005 req_data  input  NUM_REQ*DATA_WIDTH  per-requester transmit word, slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 gnt  output  NUM_REQ  one-hot grant, held for the whole transaction.
REQ-007 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-008 err  output  NUM_REQ  one-cycle timeout pulse to the granted requester.
REQ-009 rdata  output  DATA_WIDTH  received word; valid in the done cycle, held until the next capture.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 m_start  output  1  one-cycle start pulse to the SPI master.
REQ-012 m_data_in  output  DATA_WIDTH  transmit word to the SPI master.
REQ-013 m_cs_n  input  1  SPI master chip select.
REQ-014 m_finish  input  1  SPI master completion pulse.
REQ-015 m_data_out  input  DATA_WIDTH  SPI master received word, valid with m_finish.
REQ-016 cs_n  output  NUM_REQ  per-slave chip select: cs_n[i] = m_cs_n when gnt[i], else 1.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT, GAP.
REQ-018 IDLE: any req bit high -> latch winner into gnt, latch its req_data into m_data_in, go to START (gnt visible 1 cycle after req).
REQ-019 START: m_start=1 for exactly one cycle, clear timeout counter, go to WAIT.
REQ-020 WAIT: on m_finish -> rdata<=m_data_out, done[g]=1 next cycle, go to GAP; if timeout counter reaches TIMEOUT_CYCLES -> err[g]=1, go to GAP.
REQ-021 m_finish and timeout in the same cycle SHALL be treated as completion (done, no err).
REQ-022 GAP: gnt cleared on entry, count GAP_CYCLES cycles, then go to IDLE.
REQ-023 Arbitration SHALL be round-robin: search starts at index (last granted + 1) mod NUM_REQ; after reset the pointer is 0, so requester 0 has highest priority.
REQ-024 Pointer SHALL update only on grant; a requester re-asserting req in its done cycle is served after all other pending requesters.
REQ-025 m_data_in and gnt SHALL stay stable from START through end of WAIT; req_data changes in that window are ignored.
REQ-026 req dropped mid-transaction SHALL NOT abort it; done/err still pulses.
REQ-027 m_finish outside WAIT SHALL be ignored.
REQ-028 Timeout counter width SHALL be clog2(TIMEOUT_CYCLES+1) with saturation, no wrap.

Reset
REQ-029 On rst_n low: state IDLE, gnt=0, done=0, err=0, rdata=0, busy=0, m_start=0, m_data_in=0, cs_n all 1, RR pointer 0, counters 0.
REQ-030 Reset mid-transaction SHALL abandon it with no done/err pulse; the SPI master shares rst_n.

Structure
REQ-031 Package spi_arb_pkg SHALL hold the state encoding and default parameter constants.
REQ-032 The round-robin selector SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot winner, combinational).

Verification
REQ-033 Single request: req=4'b0100, req_data[2]=6'h2A, master loopback -> gnt=4'b0100 next cycle, one m_start, m_data_in=6'h2A, done=4'b0100 with rdata=6'h2A, cs_n=4'b1011 while m_cs_n low.
REQ-034 Contention: req=4'b1111 held from reset -> grant order 0,1,2,3,0, each separated by GAP_CYCLES idle cycles.
REQ-035 Timeout: m_finish tied low -> err[g] pulses TIMEOUT_CYCLES cycles after m_start, no done, FSM returns to IDLE.
REQ-036 m_finish in the timeout-expiry cycle -> done pulses, err stays 0.
REQ-037 rst_n low during WAIT -> all outputs at reset values next cycle, no done/err; new req afterwards granted to requester 0 first.
REQ-038 Requester drops req in WAIT and req_data changes -> transaction completes with the original word, done still pulses.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI request arbiter: FSM state encoding and
// the default values of the top-level parameters.
// Ports: none (package).
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 6;
    localparam int DEF_GAP_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: returns the first requester found when searching
// upward from ptr_i, wrapping at NUM_REQ. Purely combinational.
// Ports: req_i (request vector), ptr_i (search start index), win_o (one-hot winner, 0 if no request).
module rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master between NUM_REQ requesters: round-robin grant,
// one transaction at a time, timeout guard, fixed idle gap between transactions.
// Ports: clk/rst_n; requester side req/req_data -> gnt/done/err/rdata/busy;
//        master side m_start/m_data_in -> m_cs_n/m_finish/m_data_out; per-slave cs_n.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic                          m_start,
    output logic [DATA_WIDTH-1:0]         m_data_in,
    input  logic                          m_cs_n,
    input  logic                          m_finish,
    input  logic [DATA_WIDTH-1:0]         m_data_out,
    output logic [NUM_REQ-1:0]            cs_n
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    arb_state_e state_q, state_d;

    logic [NUM_REQ-1:0]    gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, m_data_in_q, m_data_in_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;

    logic [NUM_REQ-1:0]    win;
    logic [PTR_W-1:0]      win_idx;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  to_hit, gap_end;

    // to_cnt_q counts WAIT cycles from 0, so the cycle with to_cnt_q ==
    // TIMEOUT_CYCLES-1 is TIMEOUT_CYCLES cycles after the m_start cycle: the
    // last cycle an m_finish is still accepted. A finish in that very cycle
    // wins over the timeout because it is tested first below.
    assign to_hit  = (to_cnt_q >= TO_LAST);
    assign gap_end = (gap_cnt_q >= GAP_LAST);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (win)
    );

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx  = PTR_W'(i);
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (m_finish || to_hit) state_d = ST_GAP;
            ST_GAP:   if (gap_end) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy    = (state_q != ST_IDLE);
        m_start = (state_q == ST_START);
    end

    // Datapath next-state: grant/word are latched only in IDLE, so req and
    // req_data may change freely for the rest of the transaction.
    always_comb begin
        gnt_d       = gnt_q;
        done_d      = '0;
        err_d       = '0;
        rdata_d     = rdata_q;
        m_data_in_d = m_data_in_q;
        ptr_d       = ptr_q;
        to_cnt_d    = to_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d       = win;
                    m_data_in_d = win_data;
                    ptr_d       = (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
                end
            end
            ST_START: to_cnt_d = '0;
            ST_WAIT: begin
                if (m_finish) begin
                    done_d    = gnt_q;
                    rdata_d   = m_data_out;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                end else if (to_hit) begin
                    err_d     = gnt_q;
                    gnt_d     = '0;
                    gap_cnt_d = '0;
                end else if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_GAP: begin
                if (!gap_end) gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            m_data_in_q <= '0;
            ptr_q       <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
        end else begin
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            m_data_in_q <= m_data_in_d;
            ptr_q       <= ptr_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cs_n[i] = gnt_q[i] ? m_cs_n : 1'b1;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign m_data_in = m_data_in_q;

endmodule
